// File: rtl/msrv32_dmem_responder.sv
// rtl/msrv32_dmem_responder.sv - AHB-Lite-style data-memory responder for the MSRV32 store/load bus (optional DMEM_ERR_EN)
module msrv32_dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [1:0]  ahb_htrans_in,
    input  logic [31:0] d_addr_in,
    input  logic        wr_req_in,
    input  logic [3:0]  wr_mask_in,
    input  logic [31:0] data_in,
    output logic        ahb_ready_out,
    output logic [31:0] rdata_out,
    output logic        ahb_resp_out
);

    localparam int         WORDS = 2 ** DEPTH_LOG2;
    localparam logic [2:0] WS    = WAIT_STATES[2:0];

    // ERR1/ERR2 are only reachable when the address-range check is built in
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    state_t                  req_target;
    logic [2:0]              wait_cnt;
    logic [DEPTH_LOG2-1:0]   cap_idx;
    logic                    cap_wr;
    logic [3:0]              cap_mask;
    logic                    req;
    logic                    addr_err;
    logic [31:0]             mem [0:WORDS-1];

    // Byte offset is dropped: the store unit already lane-aligns the mask
    logic unused_addr;
    assign unused_addr = ^{d_addr_in[1:0], d_addr_in[31:DEPTH_LOG2+2]};

    // A transfer is only accepted while the previous data phase is completing
    assign req = ahb_ready_out && ahb_htrans_in[1];

`ifdef DMEM_ERR_EN
    assign addr_err = |d_addr_in[31:DEPTH_LOG2+2];
`else
    assign addr_err = 1'b0;
`endif

    // Where a freshly sampled request takes the FSM
    always_comb begin
        req_target = S_DATA;
        if (addr_err) begin
            req_target = S_ERR1;
        end else if (WAIT_STATES > 0) begin
            req_target = S_WAIT;
        end
    end

    // State register
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DATA and ERR2 accept pipelined back-to-back requests
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = req ? req_target : S_IDLE;
            S_WAIT:  state_nxt = (wait_cnt == 3'd1) ? S_DATA : S_WAIT;
            S_DATA:  state_nxt = req ? req_target : S_IDLE;
            S_ERR1:  state_nxt = S_ERR2;
            S_ERR2:  state_nxt = req ? req_target : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: ready drops only while stalling or in the first error cycle
    always_comb begin
        ahb_ready_out = 1'b1;
        ahb_resp_out  = 1'b0;
        rdata_out     = 32'h0;
        case (state)
            S_WAIT: ahb_ready_out = 1'b0;
            S_DATA: rdata_out     = mem[cap_idx];
`ifdef DMEM_ERR_EN
            S_ERR1: begin
                ahb_ready_out = 1'b0;
                ahb_resp_out  = 1'b1;
            end
            S_ERR2: ahb_resp_out = 1'b1;
`endif
            default: ;
        endcase
    end

    // Address-phase capture and wait-state counter
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            cap_idx  <= '0;
            cap_wr   <= 1'b0;
            cap_mask <= 4'h0;
            wait_cnt <= 3'd0;
        end else begin
            if (req) begin
                cap_idx  <= d_addr_in[DEPTH_LOG2+1:2];
                cap_wr   <= wr_req_in && !addr_err;
                cap_mask <= wr_mask_in;
            end
            if (req && !addr_err && (WAIT_STATES > 0)) begin
                wait_cnt <= WS;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    // Byte-lane write commit on the edge that closes a write data phase;
    // reset forces IDLE asynchronously so an aborted transfer never commits
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (state == S_DATA && cap_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_mask[i]) begin
                    mem[cap_idx][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// tb/tb_msrv32_dmem_responder.sv - directed self-checking bench for msrv32_dmem_responder
`timescale 1ns/1ps
module tb_msrv32_dmem_responder;

    // Index 0: WAIT_STATES=0, index 1: WAIT_STATES=2, index 2: WAIT_STATES=3
    logic        clk = 1'b0;
    logic        rst   [3];
    logic [1:0]  tr    [3];
    logic [31:0] addr  [3];
    logic        wr    [3];
    logic [3:0]  mask  [3];
    logic [31:0] wdata [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        resp  [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    msrv32_dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst[0]),
        .ahb_htrans_in(tr[0]), .d_addr_in(addr[0]), .wr_req_in(wr[0]),
        .wr_mask_in(mask[0]), .data_in(wdata[0]),
        .ahb_ready_out(ready[0]), .rdata_out(rdata[0]), .ahb_resp_out(resp[0]));

    msrv32_dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut1 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst[1]),
        .ahb_htrans_in(tr[1]), .d_addr_in(addr[1]), .wr_req_in(wr[1]),
        .wr_mask_in(mask[1]), .data_in(wdata[1]),
        .ahb_ready_out(ready[1]), .rdata_out(rdata[1]), .ahb_resp_out(resp[1]));

    msrv32_dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3)) dut2 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst[2]),
        .ahb_htrans_in(tr[2]), .d_addr_in(addr[2]), .wr_req_in(wr[2]),
        .wr_mask_in(mask[2]), .data_in(wdata[2]),
        .ahb_ready_out(ready[2]), .rdata_out(rdata[2]), .ahb_resp_out(resp[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ap(input int d, input logic [1:0] t, input logic [31:0] a,
                      input logic w, input logic [3:0] m);
        tr[d]   = t;
        addr[d] = a;
        wr[d]   = w;
        mask[d] = m;
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [3:0] m,
                            input logic [31:0] v);
        int n;
        ap(d, 2'b10, a, 1'b1, m);
        tick();
        tr[d]    = 2'b00;
        wdata[d] = v;
        n = 0;
        while (ready[d] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 20) begin
            fails++;
            $display("FAIL write_timeout dut%0d addr %h: ready never rose", d, a);
        end
        tick();
    endtask

    task automatic do_read(input int d, input logic [31:0] a, output logic [31:0] v);
        int n;
        ap(d, 2'b10, a, 1'b0, 4'h0);
        tick();
        tr[d] = 2'b00;
        n = 0;
        while (ready[d] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 20) begin
            fails++;
            $display("FAIL read_timeout dut%0d addr %h: ready never rose", d, a);
        end
        v = rdata[d];
        tick();
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            ap(d, 2'b00, 32'h0, 1'b0, 4'h0);
            wdata[d] = 32'h0;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (ready[d] !== 1'b1 || rdata[d] !== 32'h0 || resp[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_idle dut%0d cyc%0d: ready=%b rdata=%h resp=%b want 1/0/0",
                             d, c, ready[d], rdata[d], resp[d]);
                end
            end
        end
    endtask

    task automatic test_word_rw();
        ap(0, 2'b10, 32'h8, 1'b1, 4'hF);
        tick();
        wdata[0] = 32'h87654321;
        ap(0, 2'b10, 32'h8, 1'b0, 4'h0);
        tests++;
        if (ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL word_wr_ready: got %b want 1", ready[0]);
        end
        tick();
        tr[0] = 2'b00;
        tests++;
        if (ready[0] !== 1'b1 || rdata[0] !== 32'h87654321) begin
            fails++;
            $display("FAIL word_rd_data: ready=%b rdata=%h want 1/87654321", ready[0], rdata[0]);
        end
        tick();
        tests++;
        if (ready[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            fails++;
            $display("FAIL word_idle_after: ready=%b rdata=%h want 1/00000000", ready[0], rdata[0]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] v;
        do_write(0, 32'h4, 4'hF, 32'hFFFFFFFF);
        do_write(0, 32'h4, 4'b1100, 32'h56780000);
        do_read(0, 32'h4, v);
        tests++;
        if (v !== 32'h5678FFFF) begin
            fails++;
            $display("FAIL lane_half: got %h want 5678ffff", v);
        end
        do_write(0, 32'h4, 4'b0010, 32'h0000AB00);
        do_read(0, 32'h4, v);
        tests++;
        if (v !== 32'h5678ABFF) begin
            fails++;
            $display("FAIL lane_byte: got %h want 5678abff", v);
        end
        do_write(0, 32'h4, 4'b0000, 32'h12345678);
        do_read(0, 32'h4, v);
        tests++;
        if (v !== 32'h5678ABFF) begin
            fails++;
            $display("FAIL lane_none: got %h want 5678abff", v);
        end
    endtask

    task automatic test_back_to_back();
        ap(0, 2'b10, 32'h40, 1'b1, 4'hF);
        tick();
        wdata[0] = 32'h11223344;
        ap(0, 2'b10, 32'h44, 1'b1, 4'hF);
        tick();
        wdata[0] = 32'h55667788;
        ap(0, 2'b10, 32'h48, 1'b1, 4'hF);
        tick();
        wdata[0] = 32'h99AABBCC;
        ap(0, 2'b10, 32'h40, 1'b0, 4'h0);
        tick();
        tests++;
        if (rdata[0] !== 32'h11223344 || ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_rd0: rdata=%h ready=%b want 11223344/1", rdata[0], ready[0]);
        end
        ap(0, 2'b11, 32'h44, 1'b0, 4'h0);
        tick();
        tests++;
        if (rdata[0] !== 32'h55667788 || ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_rd1: rdata=%h ready=%b want 55667788/1", rdata[0], ready[0]);
        end
        ap(0, 2'b11, 32'h48, 1'b0, 4'h0);
        tick();
        tests++;
        if (rdata[0] !== 32'h99AABBCC || ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_rd2: rdata=%h ready=%b want 99aabbcc/1", rdata[0], ready[0]);
        end
        tr[0] = 2'b00;
        tick();
        tests++;
        if (rdata[0] !== 32'h0) begin
            fails++;
            $display("FAIL b2b_idle: rdata=%h want 00000000", rdata[0]);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] v;
        do_write(1, 32'h24, 4'hF, 32'h11111111);
        ap(1, 2'b10, 32'h20, 1'b1, 4'hF);
        tick();
        tests++;
        if (ready[1] !== 1'b0) begin
            fails++;
            $display("FAIL ws_n1: ready=%b want 0", ready[1]);
        end
        ap(1, 2'b10, 32'h24, 1'b1, 4'hF);
        wdata[1] = 32'hCAFEF00D;
        tick();
        tests++;
        if (ready[1] !== 1'b0) begin
            fails++;
            $display("FAIL ws_n2: ready=%b want 0", ready[1]);
        end
        tr[1] = 2'b00;
        tick();
        tests++;
        if (ready[1] !== 1'b1) begin
            fails++;
            $display("FAIL ws_n3: ready=%b want 1", ready[1]);
        end
        tick();
        tests++;
        if (ready[1] !== 1'b1) begin
            fails++;
            $display("FAIL ws_idle: ready=%b want 1", ready[1]);
        end
        do_read(1, 32'h20, v);
        tests++;
        if (v !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL ws_commit: got %h want cafef00d", v);
        end
        do_read(1, 32'h24, v);
        tests++;
        if (v !== 32'h11111111) begin
            fails++;
            $display("FAIL ws_ignored_addr: got %h want 11111111", v);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] v;
        do_write(2, 32'h10, 4'hF, 32'h0BADBEEF);
        ap(2, 2'b10, 32'h10, 1'b1, 4'hF);
        tick();
        tests++;
        if (ready[2] !== 1'b0) begin
            fails++;
            $display("FAIL rmw_wait: ready=%b want 0", ready[2]);
        end
        tr[2]    = 2'b00;
        wdata[2] = 32'hDEADDEAD;
        rst[2]   = 1'b1;
        #1;
        tests++;
        if (ready[2] !== 1'b1 || rdata[2] !== 32'h0 || resp[2] !== 1'b0) begin
            fails++;
            $display("FAIL rmw_async: ready=%b rdata=%h resp=%b want 1/0/0", ready[2], rdata[2], resp[2]);
        end
        tick();
        tick();
        rst[2] = 1'b0;
        tick();
        do_read(2, 32'h10, v);
        tests++;
        if (v !== 32'h0BADBEEF) begin
            fails++;
            $display("FAIL rmw_nowrite: got %h want 0badbeef", v);
        end
    endtask

    task automatic test_addr_err();
        logic [31:0] v;
`ifdef DMEM_ERR_EN
        do_write(0, 32'h0, 4'hF, 32'h2468ACE0);
        ap(0, 2'b10, 32'h00001000, 1'b1, 4'hF);
        tick();
        tr[0]    = 2'b00;
        wdata[0] = 32'hFFFFFFFF;
        tests++;
        if (ready[0] !== 1'b0 || resp[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            fails++;
            $display("FAIL err_c1: ready=%b resp=%b rdata=%h want 0/1/0", ready[0], resp[0], rdata[0]);
        end
        tick();
        tests++;
        if (ready[0] !== 1'b1 || resp[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            fails++;
            $display("FAIL err_c2: ready=%b resp=%b rdata=%h want 1/1/0", ready[0], resp[0], rdata[0]);
        end
        tick();
        tests++;
        if (resp[0] !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: resp=%b want 0", resp[0]);
        end
        do_read(0, 32'h0, v);
        tests++;
        if (v !== 32'h2468ACE0) begin
            fails++;
            $display("FAIL err_nowrite: got %h want 2468ace0", v);
        end
`else
        do_write(0, 32'h00001000, 4'hF, 32'h13572468);
        tests++;
        if (resp[0] !== 1'b0) begin
            fails++;
            $display("FAIL wrap_resp: resp=%b want 0", resp[0]);
        end
        do_read(0, 32'h0, v);
        tests++;
        if (v !== 32'h13572468) begin
            fails++;
            $display("FAIL wrap_word0: got %h want 13572468", v);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_wait();
        test_addr_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
